// File: rtl/udma_external_per_endpoint.sv
// udma_external_per_endpoint
//   Peripheral-domain endpoint of the uDMA external-peripheral channel.
//   Takes words from the bridge TX stream, transforms them according to the
//   latched mode (pass, invert, byte-reverse, accumulate), and returns the
//   results on the RX stream through a small output FIFO.
// Ports:
//   clk_i, rst_i            single clock, synchronous active-high reset
//   setup_i[31:0]           [0] enable, [2:1] mode, [31:16] frame length
//   status_o[31:0]          [15:0] count, [16] busy, [17] done, [18] abort,
//                           [21:19] FIFO level
//   tx_valid_i/tx_ready_o/tx_data_i   inbound stream
//   rx_valid_o/rx_ready_i/rx_data_o   outbound stream
module udma_external_per_endpoint #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           setup_i,
  output logic [31:0]           status_o,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
  localparam logic [LW-1:0]        LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]        LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q;
  logic [CNT_WIDTH-1:0]   len_q, cnt_q;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic                   done_q, abort_q;

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_q, rd_q;
  logic [LW-1:0]          level_q;

  logic                   en;
  logic                   accept, push, pop, abort_now, busy;
  logic [DATA_WIDTH-1:0]  push_data;

  function automatic logic [DATA_WIDTH-1:0] xform(input logic [1:0] m,
                                                  input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    case (m)
      2'd1: r = ~d;
      2'd2: for (int unsigned b = 0; b < DATA_WIDTH / 8; b++)
              r[8*b +: 8] = d[DATA_WIDTH-8-8*b +: 8];
      default: r = d;
    endcase
    return r;
  endfunction

  assign en         = setup_i[0];
  assign rx_valid_o = (level_q != '0);
  assign rx_data_o  = rx_valid_o ? mem[rd_q] : '0;
  assign pop        = rx_valid_o && rx_ready_i;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);

  always_comb begin
    state_d    = state_q;
    tx_ready_o = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    push_data  = xform(mode_q, tx_data_i);
    abort_now  = 1'b0;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN: begin
        // Full FIFO blocks input even if a pop happens this cycle.
        tx_ready_o = ((len_q == '0) || (cnt_q < len_q)) &&
                     ((mode_q == 2'd3) || (level_q < LVL_FULL));
        accept     = tx_valid_i && tx_ready_o;
        if (!en) begin
          state_d   = ST_IDLE;
          abort_now = 1'b1;
        end else if (accept) begin
          push = (mode_q != 2'd3);
          if ((len_q != '0) && (cnt_q + CNT_ONE == len_q))
            state_d = (mode_q == 2'd3) ? ST_FLUSH : ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (!en) begin
          state_d   = ST_IDLE;
          abort_now = 1'b1;
        end else begin
          push      = 1'b1;
          push_data = acc_q;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!en) begin
          state_d   = ST_IDLE;
          abort_now = 1'b1;
        end else if (level_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    status_o        = '0;
    status_o[15:0]  = 16'(cnt_q);
    status_o[16]    = busy;
    status_o[17]    = done_q;
    status_o[18]    = abort_q;
    status_o[21:19] = 3'(level_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !abort_now && push) mem[wr_q] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && en) begin
        mode_q  <= setup_i[2:1];
        len_q   <= setup_i[16 +: CNT_WIDTH];
        cnt_q   <= '0;
        acc_q   <= '0;
        done_q  <= 1'b0;
        abort_q <= 1'b0;
      end
      if (accept) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
        acc_q <= acc_q + tx_data_i;
      end
      if (abort_now) begin
        abort_q <= 1'b1;
        wr_q    <= '0;
        rd_q    <= '0;
        level_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PTR_ONE;
        if (pop)  rd_q <= rd_q + PTR_ONE;
        if (push && !pop)      level_q <= level_q + LVL_ONE;
        else if (pop && !push) level_q <= level_q - LVL_ONE;
      end
      if (state_q == ST_DRAIN && state_d == ST_DONE) done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udma_external_per_endpoint.sv
module tb_udma_external_per_endpoint;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] setup;
  logic [31:0] status;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;

  int checks = 0;
  int errors = 0;
  int rx_beats = 0;

  always #5 clk = ~clk;

  udma_external_per_endpoint #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .setup_i(setup), .status_o(status),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data),
    .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data)
  );

  always @(posedge clk) if (rx_valid && rx_ready) rx_beats <= rx_beats + 1;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_setup(input logic en, input logic [1:0] mode,
                                           input logic [15:0] len);
    return {len, 13'd0, mode, en};
  endfunction

  task automatic start(input logic [1:0] mode, input logic [15:0] len);
    setup = mk_setup(1'b1, mode, len);
    step();
  endtask

  task automatic stop();
    setup[0] = 1'b0;
    step();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!status[17] && n < 40) begin
      step();
      n++;
    end
    check(name, {31'd0, status[17]}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sent, got;

    vecs[0] = '{2'd1, 32'h0000FFFF, 32'hFFFF0000};
    vecs[1] = '{2'd2, 32'h12345678, 32'h78563412};
    vecs[2] = '{2'd0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3] = '{2'd1, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[4] = '{2'd2, 32'hAABBCCDD, 32'hDDCCBBAA};

    rst = 1'b1; setup = '0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_status", status, 32'h0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", rx_data, 32'h0);

    // Single-word frames, one per table entry, with the output held under backpressure.
    foreach (vecs[i]) begin
      start(vecs[i].mode, 16'd1);
      tx_valid = 1'b1; tx_data = vecs[i].din;
      check("vec_tx_ready", {31'd0, tx_ready}, 32'd1);
      step();
      tx_valid = 1'b0;
      check("vec_rx_data", rx_data, vecs[i].dout);
      step();
      check("vec_hold_valid", {31'd0, rx_valid}, 32'd1);
      check("vec_hold_data", rx_data, vecs[i].dout);
      rx_ready = 1'b1;
      wait_done("vec_done");
      check("vec_count", {16'd0, status[15:0]}, 32'd1);
      rx_ready = 1'b0;
      stop();
    end

    // Pass-through, len 4, continuous flow.
    start(2'd0, 16'd4);
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 32'h11111111 * (i + 1);
      check("pt_tx_ready", {31'd0, tx_ready}, 32'd1);
      step();
      check("pt_rx_valid", {31'd0, rx_valid}, 32'd1);
      check("pt_rx_data", rx_data, 32'h11111111 * (i + 1));
    end
    tx_valid = 1'b0;
    wait_done("pt_done");
    check("pt_count", {16'd0, status[15:0]}, 32'd4);
    check("pt_busy", {31'd0, status[16]}, 32'd0);
    stop();

    // Accumulate mode: only the sum appears on RX.
    start(2'd3, 16'd3);
    base = rx_beats;
    foreach (vecs[i]) if (i < 3) begin
      tx_valid = 1'b1;
      tx_data  = (i == 0) ? 32'hFFFFFFFF : (i == 1) ? 32'd2 : 32'd5;
      step();
      check("acc_no_rx", {31'd0, rx_valid}, 32'd0);
    end
    tx_valid = 1'b0;
    step();
    check("acc_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("acc_sum", rx_data, 32'h00000006);
    wait_done("acc_done");
    check("acc_beats", rx_beats - base, 32'd1);
    stop();

    // Backpressure: fill the FIFO, then release and check ordering.
    rx_ready = 1'b0;
    start(2'd0, 16'd8);
    base = rx_beats;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 32'hA0000000 + i;
      check("bp_fill_ready", {31'd0, tx_ready}, 32'd1);
      step();
    end
    tx_data = 32'hA0000004;
    check("bp_full_ready", {31'd0, tx_ready}, 32'd0);
    check("bp_level", {29'd0, status[21:19]}, 32'd4);
    check("bp_count4", {16'd0, status[15:0]}, 32'd4);
    check("bp_head", rx_data, 32'hA0000000);
    rx_ready = 1'b1;
    sent = 4; got = 0;
    for (int c = 0; c < 60 && !status[17]; c++) begin
      tx_valid = (sent < 8);
      tx_data  = 32'hA0000000 + sent;
      if (rx_valid) begin
        check("bp_order", rx_data, 32'hA0000000 + got);
        got++;
      end
      if (tx_valid && tx_ready) sent++;
      step();
    end
    tx_valid = 1'b0;
    check("bp_done", {31'd0, status[17]}, 32'd1);
    check("bp_beats", rx_beats - base, 32'd8);
    check("bp_count8", {16'd0, status[15:0]}, 32'd8);
    stop();

    // Abort mid-frame with words buffered.
    rx_ready = 1'b0;
    start(2'd0, 16'd8);
    base = rx_beats;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = 32'hB0000000 + i;
      step();
    end
    tx_valid = 1'b0;
    check("ab_level", {29'd0, status[21:19]}, 32'd3);
    stop();
    check("ab_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("ab_flag", {31'd0, status[18]}, 32'd1);
    check("ab_count", {16'd0, status[15:0]}, 32'd3);
    check("ab_busy", {31'd0, status[16]}, 32'd0);
    check("ab_level0", {29'd0, status[21:19]}, 32'd0);
    rx_ready = 1'b1;
    setup[0] = 1'b1;
    step();
    check("ab_reen_count", {16'd0, status[15:0]}, 32'd0);
    check("ab_reen_flag", {31'd0, status[18]}, 32'd0);
    check("ab_reen_busy", {31'd0, status[16]}, 32'd1);
    check("ab_no_emit", rx_beats - base, 32'd0);
    stop();

    // Length 0: frame never completes.
    start(2'd0, 16'd0);
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1; tx_data = i;
      step();
    end
    tx_valid = 1'b0;
    step(); step();
    check("unb_count", {16'd0, status[15:0]}, 32'd5);
    check("unb_busy", {31'd0, status[16]}, 32'd1);
    check("unb_done", {31'd0, status[17]}, 32'd0);
    stop();
    check("unb_abort", {31'd0, status[18]}, 32'd1);

    // Reset mid-frame: buffered words are dropped.
    rx_ready = 1'b0;
    start(2'd0, 16'd8);
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1'b1; tx_data = 32'hC0000000 + i;
      step();
    end
    tx_valid = 1'b0;
    check("rm_level", {29'd0, status[21:19]}, 32'd2);
    base = rx_beats;
    rst = 1'b1; setup = '0;
    step();
    rst = 1'b0;
    check("rm_status", status, 32'h0);
    check("rm_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rm_rx_data", rx_data, 32'h0);
    check("rm_tx_ready", {31'd0, tx_ready}, 32'd0);
    rx_ready = 1'b1;
    step(); step(); step();
    check("rm_no_emit", rx_beats - base, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
